vga_sync: RTL

Pixel-timing generator feeding the graphic stage. Divides the system clock down to the 640x480@60 Hz pixel rate and produces the raster coordinates `x`/`y` that the graphic stage uses to choose a colour. It also generates `hsync`/`vsync` and a `video_on` blanking flag. These three outputs are delayed by a configurable number of clocks so they stay aligned with the graphic stage's registered `rgb`.

---
 rtl/vga_sync_if.sv | 20 ++
 rtl/vga_sync.sv | 127 ++++++++++++
 2 files changed

// File: rtl/vga_sync_if.sv
// Raster-timing bundle from vga_sync to the graphic stage.
// frame_cnt exists only when VGA_SYNC_FRAMECNT_EN is defined.
interface vga_sync_if;
  logic [10:0] x;
  logic [10:0] y;
  logic        pix_tick;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic        frame_start;
`ifdef VGA_SYNC_FRAMECNT_EN
  logic [15:0] frame_cnt;

  modport master (output x, y, pix_tick, hsync, vsync, video_on, frame_start, frame_cnt);
  modport slave  (input  x, y, pix_tick, hsync, vsync, video_on, frame_start, frame_cnt);
`else
  modport master (output x, y, pix_tick, hsync, vsync, video_on, frame_start);
  modport slave  (input  x, y, pix_tick, hsync, vsync, video_on, frame_start);
`endif
endinterface

// File: rtl/vga_sync.sv
// vga_sync: 640x480@60 pixel-timing generator (clock divider, raster counters, delayed syncs).
// Define VGA_SYNC_FRAMECNT_EN to add the 16-bit frame_cnt output.
module vga_sync #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter logic        SYNC_ACTIVE = 1'b0,
  parameter int unsigned PIPE_DLY    = 1
) (
  input logic        clk,
  input logic        reset,
  vga_sync_if.master vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] Y_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [10:0] X_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] Y_VIS    = 11'(V_VISIBLE);

  logic [DIV_W-1:0] div;
  logic [10:0]      x;
  logic [10:0]      y;
  logic             tick;
  logic             frame_start;
  logic             hs_lvl;
  logic             vs_lvl;
  logic             vo_raw;

  // With CLK_DIV=1 div is pinned at 0, so tick stays high even in reset.
  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div         <= '0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (tick) begin
        div <= '0;
        if (x == X_LAST) begin
          x           <= '0;
          y           <= (y == Y_LAST) ? '0 : y + 11'd1;
          frame_start <= (y == Y_LAST);
        end else begin
          x <= x + 11'd1;
        end
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  assign hs_lvl = ((x >= HS_START) && (x < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vs_lvl = ((y >= VS_START) && (y < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vo_raw = (x < X_VIS) && (y < Y_VIS);

  assign vga.x           = x;
  assign vga.y           = y;
  assign vga.pix_tick    = tick;
  assign vga.frame_start = frame_start;

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign vga.hsync    = hs_lvl;
      assign vga.vsync    = vs_lvl;
      assign vga.video_on = vo_raw;
    end else begin : g_dly
      // Stage 0 takes the raw level; the last stage drives the port. Runs every clk.
      logic [PIPE_DLY-1:0] hs_q;
      logic [PIPE_DLY-1:0] vs_q;
      logic [PIPE_DLY-1:0] vo_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          hs_q <= {PIPE_DLY{~SYNC_ACTIVE}};
          vs_q <= {PIPE_DLY{~SYNC_ACTIVE}};
          vo_q <= '0;
        end else begin
          hs_q[0] <= hs_lvl;
          vs_q[0] <= vs_lvl;
          vo_q[0] <= vo_raw;
          for (int unsigned i = 1; i < PIPE_DLY; i++) begin
            hs_q[i] <= hs_q[i-1];
            vs_q[i] <= vs_q[i-1];
            vo_q[i] <= vo_q[i-1];
          end
        end
      end

      assign vga.hsync    = hs_q[PIPE_DLY-1];
      assign vga.vsync    = vs_q[PIPE_DLY-1];
      assign vga.video_on = vo_q[PIPE_DLY-1];
    end
  endgenerate

`ifdef VGA_SYNC_FRAMECNT_EN
  logic [15:0] frame_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign vga.frame_cnt = frame_cnt;
`endif

endmodule
